// File: rtl/axi4_write_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_write_arbiter
//
// Lets NUM_M AXI4 write masters share one write slave port (AW/W/B). An AW
// request wins the grant in round-robin order. The grant is then held until the
// winner's B handshake completes, so only one write is outstanding at a time.
// Payloads are muxed by gnt_id at all times. Only the valid and ready signals
// are gated.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   m_aw*/m_w*/m_b*         per-master channels, flattened by master index
//   m_bresp                 response broadcast to all masters
//   s_aw*/s_w*/s_b*         shared slave-side channels
//   gnt_id                  current / most recently granted master
//   busy                    high while a transaction is in XFER or RESP
// -----------------------------------------------------------------------------
module axi4_write_arbiter #(
  parameter  int NUM_M  = 4,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int ID_W   = $clog2(NUM_M)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_M-1:0]           m_awvalid,
  output logic [NUM_M-1:0]           m_awready,
  input  logic [NUM_M*ADDR_W-1:0]    m_awaddr,
  input  logic [NUM_M-1:0]           m_wvalid,
  output logic [NUM_M-1:0]           m_wready,
  input  logic [NUM_M*DATA_W-1:0]    m_wdata,
  input  logic [NUM_M*STRB_W-1:0]    m_wstrb,
  input  logic [NUM_M-1:0]           m_wlast,
  output logic [NUM_M-1:0]           m_bvalid,
  input  logic [NUM_M-1:0]           m_bready,
  output logic [1:0]                 m_bresp,
  output logic                       s_awvalid,
  input  logic                       s_awready,
  output logic [ADDR_W-1:0]          s_awaddr,
  output logic                       s_wvalid,
  input  logic                       s_wready,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [STRB_W-1:0]          s_wstrb,
  output logic                       s_wlast,
  input  logic                       s_bvalid,
  output logic                       s_bready,
  input  logic [1:0]                 s_bresp,
  output logic [ID_W-1:0]            gnt_id,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_M - 1);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic            aw_done;
  logic            w_done;

  logic [ID_W-1:0] winner;
  logic            found;
  logic            aw_hs;
  logic            wlast_hs;
  logic            b_hs;

  // Round-robin search: the first requester at or above rr_ptr, wrapping at
  // NUM_M-1. The index wraps explicitly so non-power-of-two NUM_M works.
  always_comb begin
    logic [ID_W-1:0] idx;
    // NOTE: every variable gets a default before any conditional write, so the
    // block stays purely combinational and infers no latch.
    winner = '0;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int i = 0; i < NUM_M; i++) begin
      if (!found && m_awvalid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = (idx == LAST_ID) ? '0 : idx + ID_W'(1);
    end
  end

  // Payload mux is independent of state; only the handshake signals are gated.
  assign s_awaddr = m_awaddr[int'(gnt_id) * ADDR_W +: ADDR_W];
  assign s_wdata  = m_wdata[int'(gnt_id) * DATA_W +: DATA_W];
  assign s_wstrb  = m_wstrb[int'(gnt_id) * STRB_W +: STRB_W];
  assign s_wlast  = m_wlast[gnt_id];
  assign m_bresp  = s_bresp;

  always_comb begin
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    case (state)
      XFER: begin
        s_awvalid         = m_awvalid[gnt_id] & ~aw_done;
        m_awready[gnt_id] = s_awready & ~aw_done;
        s_wvalid          = m_wvalid[gnt_id] & ~w_done;
        m_wready[gnt_id]  = s_wready & ~w_done;
      end
      RESP: begin
        m_bvalid[gnt_id] = s_bvalid;
        s_bready         = m_bready[gnt_id];
      end
      default: ;
    endcase
  end

  assign aw_hs    = s_awvalid & s_awready;
  assign wlast_hs = s_wvalid & s_wready & s_wlast;
  assign b_hs     = s_bvalid & s_bready;

  // NOTE: state is updated with non-blocking assignments, so every register
  // sees the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_id  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt_id  <= winner;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= XFER;
            busy    <= 1'b1;
          end
        end
        XFER: begin
          if (aw_hs)    aw_done <= 1'b1;
          if (wlast_hs) w_done  <= 1'b1;
          // Either flag can be set already or can complete in this cycle.
          if ((aw_done || aw_hs) && (w_done || wlast_hs)) state <= RESP;
        end
        RESP: begin
          if (b_hs) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi4_write_arbiter
//
// Self-checking bench for axi4_write_arbiter. Behavioural masters and a
// behavioural slave surround the DUT. Each issued transaction pushes an expected
// record (grant id, address, data, beat count, response) to a queue, in the
// grant order that round-robin arbitration should produce. The monitor compares
// slave-side handshakes and master-side responses against the head of the
// queue. Inputs change at posedge+1 and outputs are sampled at the negedge.
// -----------------------------------------------------------------------------
module tb_axi4_write_arbiter;

  localparam int NUM_M  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int ID_W   = $clog2(NUM_M);

  typedef struct {
    int               id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int               beats;
    logic [1:0]       resp;
  } txn_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_M-1:0]        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [NUM_M-1:0]        m_bvalid, m_bready;
  logic [NUM_M*ADDR_W-1:0] m_awaddr;
  logic [NUM_M*DATA_W-1:0] m_wdata;
  logic [NUM_M*STRB_W-1:0] m_wstrb;
  logic [1:0]              m_bresp;
  logic                    s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic                    s_bvalid, s_bready;
  logic [ADDR_W-1:0]       s_awaddr;
  logic [DATA_W-1:0]       s_wdata;
  logic [STRB_W-1:0]       s_wstrb;
  logic [1:0]              s_bresp;
  logic [ID_W-1:0]         gnt_id;
  logic                    busy;

  axi4_write_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Master model state
  logic [NUM_M-1:0]  aw_pend;
  logic [NUM_M-1:0]  mst_bready;
  logic [ADDR_W-1:0] mst_addr [NUM_M];
  logic [DATA_W-1:0] mst_data [NUM_M];
  int                w_left   [NUM_M];
  int                w_beat   [NUM_M];

  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      m_awaddr[i*ADDR_W +: ADDR_W] = mst_addr[i];
      m_wdata[i*DATA_W +: DATA_W]  = mst_data[i] + DATA_W'(w_beat[i]);
      m_wvalid[i]                  = (w_left[i] > 0);
      m_wlast[i]                   = (w_left[i] == 1);
    end
  end
  assign m_awvalid = aw_pend;
  assign m_bready  = mst_bready;
  assign m_wstrb   = '1;

  // Slave model and reference state
  int   aw_hold;
  bit   wr_pat[$];
  logic aw_got, w_got, resp_phase, mbusy;
  int   w_cnt;
  txn_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    wr_pat.delete();
    aw_pend    = '0;
    mst_bready = '1;
    for (int i = 0; i < NUM_M; i++) begin
      mst_addr[i] = '0;
      mst_data[i] = '0;
      w_left[i]   = 0;
      w_beat[i]   = 0;
    end
    aw_hold    = 0;
    s_awready  = 1'b1;
    s_wready   = 1'b1;
    s_bvalid   = 1'b0;
    s_bresp    = 2'b00;
    aw_got     = 1'b0;
    w_got      = 1'b0;
    resp_phase = 1'b0;
    mbusy      = 1'b0;
    w_cnt      = 0;
  endtask

  task automatic issue(input int id, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data, input int beats,
                       input logic [1:0] resp, input bit aw_now, input bit w_now);
    txn_t t;
    t.id = id; t.addr = addr; t.data = data; t.beats = beats; t.resp = resp;
    exp_q.push_back(t);
    mst_addr[id] = addr;
    mst_data[id] = data;
    w_beat[id]   = 0;
    if (w_now)  w_left[id]  = beats;
    if (aw_now) aw_pend[id] = 1'b1;
  endtask

  // One clock: monitor at the negedge, then update models at posedge+1.
  task automatic step();
    logic [NUM_M-1:0] hs_aw, hs_w, mask;
    logic sa, sw, swl, sb, nbusy, nresp;
    txn_t t;
    @(negedge clk);
    sa    = s_awvalid & s_awready;
    sw    = s_wvalid & s_wready;
    swl   = sw & s_wlast;
    sb    = s_bvalid & s_bready;
    hs_aw = m_awvalid & m_awready;
    hs_w  = m_wvalid & m_wready;

    check("busy", {63'd0, busy}, {63'd0, mbusy});
    if (!mbusy) begin
      check("idle_outs", 64'({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}), 64'd0);
    end else if (exp_q.size() == 0) begin
      check("sb_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      t    = exp_q[0];
      mask = NUM_M'(1) << t.id;
      check("gnt_id", 64'(gnt_id), 64'(t.id));
      check("non_gnt", 64'((m_awready | m_wready | m_bvalid) & ~mask), 64'd0);
      check("s_bready", {63'd0, s_bready}, {63'd0, resp_phase & mst_bready[t.id]});
      if (sa) begin
        check("awaddr", 64'(s_awaddr), 64'(t.addr));
        check("aw_src", 64'(hs_aw), 64'(mask));
      end
      if (sw) begin
        check("wdata", 64'(s_wdata), 64'(t.data + DATA_W'(w_cnt)));
        check("wstrb", 64'(s_wstrb), 64'({STRB_W{1'b1}}));
        check("w_src", 64'(hs_w), 64'(mask));
        w_cnt++;
      end
      if (sb) begin
        check("bvalid_vec", 64'(m_bvalid), 64'(mask));
        check("bresp", 64'(m_bresp), 64'(t.resp));
        check("w_beats", 64'(w_cnt), 64'(t.beats));
      end
    end

    nbusy = mbusy;
    if (!mbusy && (|m_awvalid)) nbusy = 1'b1;
    if (sa)  aw_got = 1'b1;
    if (swl) w_got  = 1'b1;
    nresp = resp_phase;
    if (mbusy && aw_got && w_got) nresp = 1'b1;
    if (sb) begin
      nbusy = 1'b0; nresp = 1'b0;
      aw_got = 1'b0; w_got = 1'b0; w_cnt = 0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end

    @(posedge clk);
    #1;
    mbusy      = nbusy;
    resp_phase = nresp;
    for (int i = 0; i < NUM_M; i++) begin
      if (hs_aw[i]) aw_pend[i] = 1'b0;
      if (hs_w[i]) begin
        w_left[i]--;
        w_beat[i]++;
      end
    end
    if (aw_hold > 0) aw_hold--;
    s_awready = (aw_hold == 0);
    s_wready  = (wr_pat.size() > 0) ? wr_pat.pop_front() : 1'b1;
    if (sb) s_bvalid = 1'b0;
    else if (aw_got && w_got && !s_bvalid && exp_q.size() > 0) begin
      s_bvalid = 1'b1;
      s_bresp  = exp_q[0].resp;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || mbusy) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) check("timeout_idle", 64'd1, 64'd0);
  endtask

  // Asynchronous reset from mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_outs"}, 64'({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}), 64'd0);
    check({tag, "_gnt"}, 64'(gnt_id), 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_model();
    rst_n = 1'b0;
    #1;
    check("rst_outs", 64'({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}), 64'd0);
    check("rst_gnt", 64'(gnt_id), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single master, one-cycle AW latency.
    issue(2, 32'h1000, 32'hDEADBEEF, 1, 2'b00, 1'b1, 1'b1);
    step();
    check("t1_gnt", 64'(gnt_id), 64'd2);
    check("t1_awvalid", {63'd0, s_awvalid}, 64'd1);
    check("t1_awaddr", 64'(s_awaddr), 64'h1000);
    check("t1_wdata", 64'(s_wdata), 64'hDEADBEEF);
    wait_idle(20);

    // rr_ptr is now 3: with masters 0 and 3 requesting, 3 must win first.
    issue(3, 32'h3000, 32'h33330000, 1, 2'b01, 1'b1, 1'b1);
    issue(0, 32'h0300, 32'h00003333, 1, 2'b11, 1'b1, 1'b1);
    wait_idle(40);

    do_reset("rst_a");

    // 2: contention from rr_ptr 0; master 0 re-requests and wins after master 3.
    for (int i = 0; i < NUM_M; i++)
      issue(i, 32'h2000 + 32'(i * 16), 32'hA0A0_0000 + 32'(i * 256), 1, 2'(i), 1'b1, 1'b1);
    n = 0;
    while (exp_q.size() > 3 && n < 50) begin step(); n++; end
    if (n >= 50) check("t2_timeout", 64'd1, 64'd0);
    issue(0, 32'h2400, 32'hB0B0_0000, 1, 2'b10, 1'b1, 1'b1);
    wait_idle(100);

    // 3: W valid before AW; master 1 gets no W ready until it is granted.
    issue(1, 32'h5000, 32'h5555AAAA, 1, 2'b10, 1'b0, 1'b1);
    repeat (3) begin
      step();
      check("t3_wready", {63'd0, m_wready[1]}, 64'd0);
    end
    aw_pend[1] = 1'b1;
    wait_idle(30);

    // 4: four-beat burst with a toggling slave W ready.
    wr_pat = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    issue(0, 32'h6000, 32'h60000000, 4, 2'b00, 1'b1, 1'b1);
    wait_idle(40);

    // 5: AW back-pressure; master 3 requests during RESP and waits for IDLE.
    aw_hold   = 5;
    s_awready = 1'b0;
    issue(1, 32'h7000, 32'h77777777, 2, 2'b01, 1'b1, 1'b1);
    n = 0;
    while (!resp_phase && n < 40) begin step(); n++; end
    if (n >= 40) check("t5_timeout", 64'd1, 64'd0);
    issue(3, 32'h7300, 32'h73737373, 1, 2'b11, 1'b1, 1'b1);
    wait_idle(40);

    // 6: reset after the AW handshake, before any W beat.
    issue(3, 32'h8000, 32'h88888888, 1, 2'b00, 1'b1, 1'b0);
    n = 0;
    while (!aw_got && n < 20) begin step(); n++; end
    if (n >= 20) check("t6_timeout", 64'd1, 64'd0);
    check("t6_pre_gnt", 64'(gnt_id), 64'd3);
    #2;
    do_reset("t6_rst");
    issue(2, 32'h9000, 32'h99999999, 1, 2'b10, 1'b1, 1'b1);
    step();
    check("t6_gnt", 64'(gnt_id), 64'd2);
    wait_idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_write_arbiter.md
Name: axi4_write_arbiter

Overview:
- Shares one AXI4 write slave port (AW/W/B channels) among NUM_M write masters.
- Round-robin arbitration on AW requests. The grant is held from the winning AW until that master's B handshake completes, so exactly one write transaction is outstanding at a time.
- Sits between the master-side interconnect ports and the axi4_write_fsm slave. It sequences access to that slave.

Parameters:
- NUM_M, 4, number of masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- m_awvalid  in  NUM_M  per-master AW valid.
- m_awready  out  NUM_M  per-master AW ready.
- m_awaddr  in  NUM_M*ADDR_W  flattened; master i at [i*ADDR_W +: ADDR_W].
- m_wvalid  in  NUM_M  per-master W valid.
- m_wready  out  NUM_M  per-master W ready.
- m_wdata  in  NUM_M*DATA_W  flattened per master.
- m_wstrb  in  NUM_M*DATA_W/8  flattened per master.
- m_wlast  in  NUM_M  last beat of burst.
- m_bvalid  out  NUM_M  per-master B valid.
- m_bready  in  NUM_M  per-master B ready.
- m_bresp  out  2  broadcast; meaningful only with own m_bvalid.
- s_awvalid  out  1  slave AW valid.
- s_awready  in  1  slave AW ready.
- s_awaddr  out  ADDR_W  muxed address.
- s_wvalid  out  1  slave W valid.
- s_wready  in  1  slave W ready.
- s_wdata  out  DATA_W  muxed data.
- s_wstrb  out  DATA_W/8  muxed strobe.
- s_wlast  out  1  muxed wlast.
- s_bvalid  in  1  slave B valid.
- s_bready  out  1  slave B ready.
- s_bresp  in  2  slave response.
- gnt_id  out  $clog2(NUM_M)  current/last granted master.
- busy  out  1  high in XFER or RESP.

Behaviour:

State machine (three states, registered):
- IDLE:
  - Request vector is m_awvalid only. W-first masters wait.
  - If any bit is set, pick the first set bit at or after rr_ptr, searching upward with wrap.
  - On that edge: gnt_id <= winner, aw_done <= 0, w_done <= 0, state -> XFER.
  - No request: stay in IDLE.
- XFER:
  - s_awvalid = m_awvalid[g] & ~aw_done; m_awready[g] = s_awready & ~aw_done.
  - s_wvalid = m_wvalid[g] & ~w_done; m_wready[g] = s_wready & ~w_done.
  - aw_done is set on the AW handshake.
  - w_done is set on a W handshake with wlast=1. Non-last beats pass through unchanged.
  - AW and W handshakes complete in either order or in the same cycle.
  - When both done (registered flags, or the handshakes of this cycle), state -> RESP on the next edge.
- RESP:
  - m_bvalid[g] = s_bvalid; s_bready = m_bready[g]; m_bresp = s_bresp.
  - On B handshake: state -> IDLE, rr_ptr <= (g+1) mod NUM_M.

Latency:
- The winner's AW is presented to the slave 1 cycle after its m_awvalid is seen in IDLE.
- One idle cycle follows each B handshake before the next grant. Minimum transaction length is 3 cycles.

Datapath and muxing:
- Slave-side payloads (awaddr, wdata, wstrb, wlast) are combinationally muxed by gnt_id in all states.
- Only the valid signals are gated.

Non-granted masters and reset:
- Non-granted masters: m_awready, m_wready, m_bvalid = 0 at all times.
- In IDLE, every ready/valid output is 0.
- Reset values: state IDLE, rr_ptr 0, gnt_id 0, aw_done/w_done 0, busy 0.
- Reset values of all ready/valid outputs: s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid all 0.
- Reset mid-transaction aborts immediately to these values; no response is generated.

Boundary conditions:
- A master deasserting m_awvalid after grant but before handshake is a protocol violation. The grant is still held and the block stays in XFER.
- Winner equals the previous owner only if it is the sole requester.
- NUM_M not a power of two: rr_ptr wraps at NUM_M-1 -> 0.
- s_bvalid in IDLE/XFER: s_bready=0 and the response is ignored.
- s_bresp passes through unmodified, including SLVERR/DECERR.

Test Plan:
1. Single master: m_awvalid[2]=1, addr 0x1000, wdata 0xDEADBEEF, wlast=1, all readies 1.
   -> gnt_id=2; s_awaddr=0x1000 and s_wdata=0xDEADBEEF one cycle later; m_bvalid=0b0100 in RESP; idle after bready; rr_ptr=3.
2. Contention: m_awvalid=0b1111 held across four transactions.
   -> grant order 0,1,2,3. Then 0 again with rr_ptr wrapping.
3. W before AW: master 1 asserts wvalid 3 cycles before awvalid.
   -> m_wready[1]=0 until granted; after grant, AW and W complete; one transaction, bresp from slave (2'b10) delivered to master 1 only.
4. Burst: 4 beats, wlast on beat 4, s_wready toggling 1,0,1,1,0,1.
   -> exactly 4 W handshakes; RESP entered only after the wlast beat and the AW handshake; s_wvalid low after the last beat.
5. Backpressure/simultaneous: s_awready held 0 for 5 cycles while W completes, then AW and B paths complete; master 3 raises awvalid during RESP.
   -> master 3 is not granted until IDLE; m_bvalid[3]=0 throughout.
6. Reset mid-XFER: assert rst_n=0 after the AW handshake and before W.
   -> all valid/ready outputs 0 asynchronously; gnt_id=0, busy=0; post-reset request from master 2 granted normally.
